multi_cycle_ctrl: RTL and testbench

Control unit for the multi-cycle MIPS core that follows the single-cycle `top_for_single` design. It sequences one shared ALU, one unified instruction/data memory and the register file through the fetch, decode, execute, memory and writeback steps. It is a Moore state machine with a small amount of Mealy gating on `zero` and `mem_ready`. It sits between the instruction register (it consumes `opcode` and `funct`) and the datapath muxes and write enables. It also exports `state` to the seven-segment debug display.

---
 rtl/multi_cycle_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_multi_cycle_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS control unit: sequences fetch/decode/execute/memory/writeback
// through one ALU, one unified memory and the register file.
module multi_cycle_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       ext_zero,
  output logic [2:0] alu_ctrl,
  output logic [1:0] pc_source,
  output logic [3:0] state
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_NOR = 3'b100;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [3:0] {
    S_IF  = 4'd0,  S_ID  = 4'd1,  S_MA  = 4'd2,  S_MR  = 4'd3,
    S_LWB = 4'd4,  S_MW  = 4'd5,  S_RX  = 4'd6,  S_RWB = 4'd7,
    S_BR  = 4'd8,  S_J   = 4'd9,  S_IX  = 4'd10, S_IWB = 4'd11,
    S_JAL = 4'd12, S_JR  = 4'd13
  } state_t;

  state_t cur;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur <= S_IF;
    end else begin
      case (cur)
        S_IF:  if (mem_ready) cur <= S_ID;
        S_ID: begin
          case (opcode)
            OP_LW, OP_SW:                     cur <= S_MA;
            OP_RTYPE:                         cur <= (funct == FN_JR) ? S_JR : S_RX;
            OP_BEQ, OP_BNE:                   cur <= S_BR;
            OP_J:                             cur <= S_J;
            OP_JAL:                           cur <= S_JAL;
            OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: cur <= S_IX;
            default:                          cur <= S_IF;
          endcase
        end
        S_MA:  cur <= (opcode == OP_LW) ? S_MR : S_MW;
        S_MR:  if (mem_ready) cur <= S_LWB;
        S_MW:  if (mem_ready) cur <= S_IF;
        S_RX:  cur <= S_RWB;
        S_IX:  cur <= S_IWB;
        default: cur <= S_IF;
      endcase
    end
  end

  logic [2:0] rx_ctrl;
  logic [2:0] ix_ctrl;
  logic       ix_zext;

  always_comb begin
    case (funct)
      6'b100010: rx_ctrl = ALU_SUB;
      6'b100100: rx_ctrl = ALU_AND;
      6'b100101: rx_ctrl = ALU_OR;
      6'b101010: rx_ctrl = ALU_SLT;
      6'b100111: rx_ctrl = ALU_NOR;
      default:   rx_ctrl = ALU_ADD;
    endcase
    ix_zext = 1'b0;
    case (opcode)
      OP_ANDI: begin ix_ctrl = ALU_AND; ix_zext = 1'b1; end
      OP_ORI:  begin ix_ctrl = ALU_OR;  ix_zext = 1'b1; end
      OP_SLTI: ix_ctrl = ALU_SLT;
      default: ix_ctrl = ALU_ADD;
    endcase
  end

  // Moore decode of the current state; rst_n gates everything so IF's strobes
  // stay quiet while reset is held.
  always_comb begin
    pc_write   = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = '0;
    mem_to_reg = '0;
    alu_src_a  = 1'b0;
    alu_src_b  = '0;
    ext_zero   = 1'b0;
    alu_ctrl   = '0;
    pc_source  = '0;
    if (rst_n) begin
      case (cur)
        S_IF: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          alu_ctrl  = ALU_ADD;
          pc_write  = mem_ready;
          ir_write  = mem_ready;
        end
        S_ID: begin
          alu_src_b = 2'b11;
          alu_ctrl  = ALU_ADD;
        end
        S_MA: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          alu_ctrl  = ALU_ADD;
        end
        S_MR: begin
          mem_read = 1'b1;
          iord     = 1'b1;
        end
        S_LWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 2'b01;
        end
        S_MW: begin
          mem_write = 1'b1;
          iord      = 1'b1;
        end
        S_RX: begin
          alu_src_a = 1'b1;
          alu_ctrl  = rx_ctrl;
        end
        S_RWB: begin
          reg_write = 1'b1;
          reg_dst   = 2'b01;
        end
        S_BR: begin
          alu_src_a = 1'b1;
          alu_ctrl  = ALU_SUB;
          pc_source = 2'b01;
          pc_write  = (opcode == OP_BNE) ? ~zero : zero;
        end
        S_J: begin
          pc_write  = 1'b1;
          pc_source = 2'b10;
        end
        S_IX: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          ext_zero  = ix_zext;
          alu_ctrl  = ix_ctrl;
        end
        S_IWB: begin
          reg_write = 1'b1;
          ext_zero  = ix_zext;
          alu_ctrl  = ix_ctrl;
        end
        S_JAL: begin
          pc_write   = 1'b1;
          pc_source  = 2'b10;
          reg_write  = 1'b1;
          reg_dst    = 2'b10;
          mem_to_reg = 2'b10;
        end
        S_JR: begin
          pc_write  = 1'b1;
          pc_source = 2'b11;
        end
        default: ;
      endcase
    end
  end

  assign state = cur;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Bench for multi_cycle_ctrl: directed scenarios plus random instruction streams
// checked cycle by cycle against an instruction-level path model.
module tb_multi_cycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode, funct;
  logic       zero, mem_ready;
  logic       pc_write, iord, mem_read, mem_write, ir_write, reg_write;
  logic [1:0] reg_dst, mem_to_reg, alu_src_b, pc_source;
  logic       alu_src_a, ext_zero;
  logic [2:0] alu_ctrl;
  logic [3:0] state;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  multi_cycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .iord(iord), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .ext_zero(ext_zero), .alu_ctrl(alu_ctrl),
    .pc_source(pc_source), .state(state)
  );

  // {pc_write,iord,mem_read,mem_write,ir_write,reg_write,reg_dst,mem_to_reg,
  //  alu_src_a,alu_src_b,ext_zero,alu_ctrl,pc_source,state}
  logic [22:0] dut_vec;
  assign dut_vec = {pc_write, iord, mem_read, mem_write, ir_write, reg_write,
                    reg_dst, mem_to_reg, alu_src_a, alu_src_b, ext_zero,
                    alu_ctrl, pc_source, state};

  task automatic check(input string tag, input logic [22:0] got, input logic [22:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %06h expected %06h", tag, got, exp);
  endtask

  // Expected control word for one cycle spent in step p of an instruction.
  function automatic logic [22:0] exp_out(input int p, input logic [5:0] op,
                                          input logic [5:0] fn, input logic z,
                                          input logic mr);
    logic pw = 0, io = 0, rd_ = 0, wr = 0, irw = 0, rw = 0, a = 0, ez = 0;
    logic [1:0] dst = 0, m2r = 0, b = 0, ps = 0;
    logic [2:0] ac = 0;
    case (p)
      0:  begin rd_ = 1; b = 1; ac = 3'b010; pw = mr; irw = mr; end
      1:  begin b = 3; ac = 3'b010; end
      2:  begin a = 1; b = 2; ac = 3'b010; end
      3:  begin rd_ = 1; io = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin wr = 1; io = 1; end
      6:  begin
            a = 1;
            ac = (fn == 6'h22) ? 3'b110 : (fn == 6'h24) ? 3'b000 :
                 (fn == 6'h25) ? 3'b001 : (fn == 6'h2a) ? 3'b111 :
                 (fn == 6'h27) ? 3'b100 : 3'b010;
          end
      7:  begin rw = 1; dst = 1; end
      8:  begin a = 1; ac = 3'b110; ps = 1; pw = (op == 6'h04) ? z : ~z; end
      9:  begin pw = 1; ps = 2; end
      10, 11: begin
            if (p == 10) begin a = 1; b = 2; end else rw = 1;
            ez = (op == 6'h0c) || (op == 6'h0d);
            ac = (op == 6'h0c) ? 3'b000 : (op == 6'h0d) ? 3'b001 :
                 (op == 6'h0a) ? 3'b111 : 3'b010;
          end
      12: begin pw = 1; ps = 2; rw = 1; dst = 2; m2r = 2; end
      13: begin pw = 1; ps = 3; end
      default: ;
    endcase
    return {pw, io, rd_, wr, irw, rw, dst, m2r, a, b, ez, ac, ps, 4'(p)};
  endfunction

  task automatic step(input int p, input logic [5:0] op, input logic [5:0] fn,
                      input logic mr, input logic z);
    opcode = op; funct = fn; mem_ready = mr; zero = z;
    @(negedge clk);
    check($sformatf("st%0d_op%02h_fn%02h_mr%0d_z%0d", p, op, fn, mr, z),
          dut_vec, exp_out(p, op, fn, z, mr));
    @(posedge clk); #1;
  endtask

  // zmode < 0 randomizes zero each cycle.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input int unsigned stall_if, input int unsigned stall_mem,
                           input int zmode);
    int path[$];
    path = '{0, 1};
    case (op)
      6'h23: path = {path, 2, 3, 4};
      6'h2b: path = {path, 2, 5};
      6'h00: if (fn == 6'h08) path.push_back(13); else path = {path, 6, 7};
      6'h04, 6'h05: path.push_back(8);
      6'h02: path.push_back(9);
      6'h03: path.push_back(12);
      6'h08, 6'h0c, 6'h0d, 6'h0a: path = {path, 10, 11};
      default: ;
    endcase
    foreach (path[k]) begin
      int p = path[k];
      bit waits = (p == 0) || (p == 3) || (p == 5);
      int unsigned n = (p == 0) ? stall_if : (waits ? stall_mem : 0);
      for (int unsigned c = 0; c <= n; c++) begin
        logic mr = waits ? (c == n) : 1'($urandom);
        logic z  = (zmode < 0) ? 1'($urandom) : 1'(zmode);
        step(p, op, fn, mr, z);
      end
    end
  endtask

  logic [5:0] op_tab [12] = '{6'h23, 6'h2b, 6'h00, 6'h00, 6'h04, 6'h05,
                              6'h02, 6'h03, 6'h08, 6'h0c, 6'h0d, 6'h0a};
  logic [5:0] fn_tab [7]  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h27, 6'h08};

  initial begin
    rst_n = 1'b0; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mem_ready = 1'($urandom);
      @(negedge clk);
      check("reset_hold", dut_vec, '0);
      @(posedge clk); #1;
    end
    rst_n = 1'b1;

    // Fetch stalled 2 cycles after reset, then lw
    run_instr(6'h23, 6'h00, 2, 0, -1);
    run_instr(6'h00, 6'h22, 0, 0, -1);
    run_instr(6'h00, 6'h08, 0, 0, -1);
    run_instr(6'h04, 6'h00, 0, 0, 1);
    run_instr(6'h04, 6'h00, 0, 0, 0);
    run_instr(6'h05, 6'h00, 0, 0, 1);
    run_instr(6'h05, 6'h00, 0, 0, 0);
    run_instr(6'h2b, 6'h00, 0, 2, -1);
    run_instr(6'h3f, 6'h00, 0, 0, -1);
    run_instr(6'h02, 6'h00, 0, 0, -1);
    run_instr(6'h03, 6'h00, 0, 0, -1);
    run_instr(6'h0d, 6'h00, 1, 0, -1);

    // Reset dropped while waiting in MR
    step(0, 6'h23, 6'h00, 1'b1, 1'b0);
    step(1, 6'h23, 6'h00, 1'b1, 1'b0);
    step(2, 6'h23, 6'h00, 1'b1, 1'b0);
    mem_ready = 1'b0;
    @(negedge clk);
    check("mr_wait", dut_vec, exp_out(3, 6'h23, 6'h00, 1'b0, 1'b0));
    #2 rst_n = 1'b0;
    #1 check("reset_async", dut_vec, '0);
    mem_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("reset_after_abort", dut_vec, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_instr(6'h00, 6'h25, 0, 0, -1);

    for (int i = 0; i < 150; i++) begin
      int unsigned sel = $urandom_range(0, 12);
      logic [5:0] op = (sel == 12) ? 6'($urandom) : op_tab[sel];
      int unsigned fs = $urandom_range(0, 7);
      logic [5:0] fn = (fs == 7) ? 6'($urandom) : fn_tab[fs];
      run_instr(op, fn, $urandom_range(0, 2), $urandom_range(0, 3), -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
